ntt_dispatcher: RTL and testbench

NTT_DISPATCHER -- requirements
Module: ntt_dispatcher

---
 rtl/ntt_dispatcher_if.sv | 24 ++
 rtl/ntt_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_ntt_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_dispatcher_if.sv
// Command bus into the NTT dispatcher.
// Valid/ready handshake carrying opcode and DMA address.
interface ntt_dispatcher_if #(
  parameter int ADDR_W = 56
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    output cmd_ready
  );
endinterface

// File: rtl/ntt_dispatcher.sv
// NTT dispatcher: queues commands and hands them out round-robin
// to idle engines, tracking occupancy, completions and halt.
module ntt_dispatcher #(
  parameter int NUM_ENG    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 56
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ntt_dispatcher_if.slave        cmd,
  output logic [NUM_ENG-1:0]     eng_start,
  output logic [NUM_ENG-1:0]     eng_mode,
  output logic [64*NUM_ENG-1:0]  eng_addr,
  input  logic [NUM_ENG-1:0]     eng_done,
  output logic [NUM_ENG-1:0]     eng_busy,
  output logic                   halted,
  output logic [31:0]            cmpl_cnt,
  output logic                   err_spurious
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t               r_state;
  logic [1:0]           r_op   [FIFO_DEPTH];
  logic [ADDR_W-1:0]    r_addr [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_rdy_en;
  logic                 r_halt_seen;
  logic [EW-1:0]        r_rr;
  logic [NUM_ENG-1:0]   r_start;
  logic [NUM_ENG-1:0]   r_mode;
  logic [64*NUM_ENG-1:0] r_eng_addr;
  logic [NUM_ENG-1:0]   r_busy;
  logic                 r_halted;
  logic [31:0]          r_cnt;
  logic                 r_err;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_ready;
  logic                 w_push;
  logic [1:0]           w_head_op;
  logic [ADDR_W-1:0]    w_head_addr;
  logic                 w_head_ntt;
  logic                 w_found;
  logic [EW-1:0]        w_sel;
  logic                 w_dispatch;
  logic                 w_pop;
  logic [NUM_ENG-1:0]   w_disp_vec;
  logic [NUM_ENG-1:0]   w_done_ok;
  logic                 w_done_bad;
  logic [31:0]          w_done_n;
  logic [63:0]          w_addr64;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  // r_rdy_en keeps ready low while in reset and for the first edge after
  assign w_ready     = r_rdy_en && !w_full && !r_halt_seen;
  assign cmd.cmd_ready = w_ready;
  assign w_push      = cmd.cmd_valid && w_ready;
  assign w_head_op   = r_op[r_rptr];
  assign w_head_addr = r_addr[r_rptr];
  assign w_head_ntt  = (w_head_op == OP_FWD) || (w_head_op == OP_INV);

  always_comb begin
    int e;
    e       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      e = (int'(r_rr) + k) % NUM_ENG;
      if (!w_found && !r_busy[e]) begin
        w_found = 1'b1;
        w_sel   = EW'(e);
      end
    end
  end

  assign w_dispatch = (r_state == S_RUN) && !w_empty &&
                      w_head_ntt && w_found;
  assign w_pop      = (r_state == S_RUN) && !w_empty &&
                      (!w_head_ntt || w_found);

  always_comb begin
    w_disp_vec = '0;
    if (w_dispatch) w_disp_vec[w_sel] = 1'b1;
  end

  assign w_done_ok  = eng_done & r_busy;
  assign w_done_bad = |(eng_done & ~r_busy);

  always_comb begin
    w_done_n = '0;
    for (int k = 0; k < NUM_ENG; k++)
      w_done_n = w_done_n + 32'(w_done_ok[k]);
  end

  always_comb begin
    w_addr64 = '0;
    w_addr64[ADDR_W-1:0] = w_head_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdy_en    <= 1'b0;
      r_halt_seen <= 1'b0;
      r_rr        <= '0;
      r_start     <= '0;
      r_mode      <= '0;
      r_eng_addr  <= '0;
      r_busy      <= '0;
      r_halted    <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_op[i]   <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      r_rdy_en <= 1'b1;
      r_start  <= w_disp_vec;
      if (w_push) begin
        r_op[r_wptr]   <= cmd.cmd_op;
        r_addr[r_wptr] <= cmd.cmd_addr;
        r_wptr         <= r_wptr + 1'b1;
        if (cmd.cmd_op == OP_HALT) r_halt_seen <= 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_busy  <= (r_busy & ~w_done_ok) | w_disp_vec;
      r_cnt   <= r_cnt + w_done_n;
      if (w_done_bad) r_err <= 1'b1;
      if (w_dispatch) begin
        r_mode[w_sel] <= (w_head_op == OP_INV);
        r_eng_addr[64*int'(w_sel) +: 64] <= w_addr64;
        if (int'(w_sel) == NUM_ENG - 1) r_rr <= '0;
        else r_rr <= w_sel + 1'b1;
      end
      unique case (r_state)
        S_RUN: begin
          if (!w_empty && w_head_op == OP_HALT) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_busy == '0) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: r_halted <= 1'b1;
        default:  r_state  <= S_RUN;
      endcase
    end
  end

  assign eng_start    = r_start;
  assign eng_mode     = r_mode;
  assign eng_addr     = r_eng_addr;
  assign eng_busy     = r_busy;
  assign halted       = r_halted;
  assign cmpl_cnt     = r_cnt;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_ntt_dispatcher.sv
// Bench for ntt_dispatcher: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_ntt_dispatcher;

  localparam int NE = 4;
  localparam int FD = 8;
  localparam int AW = 56;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_dispatcher_if #(.ADDR_W(AW)) cif ();

  logic [NE-1:0]    eng_start;
  logic [NE-1:0]    eng_mode;
  logic [64*NE-1:0] eng_addr;
  logic [NE-1:0]    eng_done;
  logic [NE-1:0]    eng_busy;
  logic             halted;
  logic [31:0]      cmpl_cnt;
  logic             err_spurious;

  ntt_dispatcher #(
    .NUM_ENG(NE),
    .FIFO_DEPTH(FD),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cif.slave),
    .eng_start(eng_start),
    .eng_mode(eng_mode),
    .eng_addr(eng_addr),
    .eng_done(eng_done),
    .eng_busy(eng_busy),
    .halted(halted),
    .cmpl_cnt(cmpl_cnt),
    .err_spurious(err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: command queue plus per-engine occupancy.
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
  } cmd_t;

  cmd_t        m_q[$];
  bit          m_busy[NE];
  int          m_rr;
  int          m_phase;
  bit          m_hs;
  bit          m_rdy;
  bit          m_halted;
  bit          m_err;
  logic [31:0] m_cnt;
  logic [NE-1:0] m_start;
  logic [NE-1:0] m_mode;
  logic [63:0] m_addr[NE];

  function automatic bit m_ready();
    return m_rdy && (m_q.size() < FD) && !m_hs;
  endfunction

  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < NE; i++) begin
      m_busy[i] = 0;
      m_addr[i] = '0;
    end
    m_rr = 0; m_phase = 0; m_hs = 0; m_rdy = 0;
    m_halted = 0; m_err = 0; m_cnt = '0;
    m_start = '0; m_mode = '0;
  endtask

  task automatic m_step(input bit v, input logic [1:0] op,
                        input logic [AW-1:0] a, input logic [NE-1:0] d);
    bit   pre[NE];
    bit   acc;
    bit   any;
    int   sel;
    int   e;
    cmd_t c;
    acc = v && m_ready();
    pre = m_busy;
    m_start = '0;
    if (m_phase == 0 && m_q.size() != 0) begin
      if (m_q[0].op == 2'b00) begin
        void'(m_q.pop_front());
      end else if (m_q[0].op == 2'b11) begin
        void'(m_q.pop_front());
        m_phase = 1;
      end else begin
        sel = -1;
        for (int k = 0; k < NE; k++) begin
          e = (m_rr + k) % NE;
          if (sel < 0 && !pre[e]) sel = e;
        end
        if (sel >= 0) begin
          m_start[sel] = 1'b1;
          m_mode[sel]  = (m_q[0].op == 2'b10);
          m_addr[sel]  = 64'(m_q[0].addr);
          m_busy[sel]  = 1;
          m_rr = (sel + 1) % NE;
          void'(m_q.pop_front());
        end
      end
    end else if (m_phase == 1) begin
      any = 0;
      for (int i = 0; i < NE; i++) any |= pre[i];
      if (!any) begin
        m_phase  = 2;
        m_halted = 1;
      end
    end
    for (int i = 0; i < NE; i++) begin
      if (d[i]) begin
        if (pre[i]) begin
          m_busy[i] = 0;
          m_cnt = m_cnt + 1;
        end else begin
          m_err = 1;
        end
      end
    end
    if (acc) begin
      c.op = op;
      c.addr = a;
      m_q.push_back(c);
      if (op == 2'b11) m_hs = 1;
    end
    m_rdy = 1;
  endtask

  task automatic check_model();
    logic [255:0] av;
    logic [NE-1:0] bv;
    av = '0;
    for (int i = 0; i < NE; i++) begin
      av[64*i +: 64] = m_addr[i];
      bv[i] = m_busy[i];
    end
    chk("cmd_ready", cif.cmd_ready, m_ready());
    chk("eng_start", eng_start, m_start);
    chk("eng_mode", eng_mode, m_mode);
    chk("eng_addr", eng_addr, av);
    chk("eng_busy", eng_busy, bv);
    chk("halted", halted, m_halted);
    chk("cmpl_cnt", cmpl_cnt, m_cnt);
    chk("err_spurious", err_spurious, m_err);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit v, input logic [1:0] op,
                     input logic [AW-1:0] a, input logic [NE-1:0] d);
    cif.cmd_valid = v;
    cif.cmd_op    = op;
    cif.cmd_addr  = a;
    eng_done      = d;
    @(posedge clk);
    m_step(v, op, a, d);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_addr  = '0;
    eng_done      = '0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_model();
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    bit            v;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [NE-1:0] d;
    logic [NE-1:0] x_start;
    logic [NE-1:0] x_busy;
    bit            x_rdy;
    logic [31:0]   x_cnt;
    logic [63:0]   x_a0;
  } vec_t;

  vec_t tv[$];

  initial begin
    int acc;
    int hcnt;
    bit v;
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [NE-1:0] d;
    int r;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_addr  = '0;
    eng_done      = '0;
    m_reset();
    @(negedge clk);

    // single forward NTT, then five back-to-back with one done
    tv.push_back('{1, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'h0, 1, 0, 64'h0});
    tv.push_back('{0, 1, 2'd1, 56'h12_3456, 4'h0, 4'h0, 4'h0, 1, 0, 64'h0});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h1, 4'h1, 1, 0, 64'h12_3456});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h1, 4'h0, 4'h0, 1, 1, 64'h12_3456});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'h0, 1, 1, 64'h12_3456});
    tv.push_back('{1, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'h0, 1, 0, 64'h0});
    tv.push_back('{0, 1, 2'd1, 56'hA1, 4'h0, 4'h0, 4'h0, 1, 0, 64'h0});
    tv.push_back('{0, 1, 2'd2, 56'hA2, 4'h0, 4'h1, 4'h1, 1, 0, 64'hA1});
    tv.push_back('{0, 1, 2'd1, 56'hA3, 4'h0, 4'h2, 4'h3, 1, 0, 64'hA1});
    tv.push_back('{0, 1, 2'd2, 56'hA4, 4'h0, 4'h4, 4'h7, 1, 0, 64'hA1});
    tv.push_back('{0, 1, 2'd1, 56'hA5, 4'h0, 4'h8, 4'hF, 1, 0, 64'hA1});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'hF, 1, 0, 64'hA1});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h4, 4'h0, 4'hB, 1, 1, 64'hA1});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h4, 4'hF, 1, 1, 64'hA1});
    tv.push_back('{0, 0, 2'd0, 56'h0, 4'h0, 4'h0, 4'hF, 1, 1, 64'hA1});

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      else cyc(tv[i].v, tv[i].op, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d_start", i), eng_start, tv[i].x_start);
      chk($sformatf("vec%0d_busy", i), eng_busy, tv[i].x_busy);
      chk($sformatf("vec%0d_ready", i), cif.cmd_ready, tv[i].x_rdy);
      chk($sformatf("vec%0d_cnt", i), cmpl_cnt, tv[i].x_cnt);
      chk($sformatf("vec%0d_addr0", i), eng_addr[63:0], tv[i].x_a0);
    end

    // fill the FIFO behind four busy engines
    do_reset();
    cyc(0, 0, '0, '0);
    acc = 0;
    for (int i = 0; i < 14; i++) begin
      if (cif.cmd_ready) acc++;
      cyc(1, 2'd1, AW'(56'h200 + i), '0);
    end
    chk("fill_accepts", acc, 12);
    chk("fill_ready_low", cif.cmd_ready, 0);
    chk("fill_busy", eng_busy, 4'hF);

    // drain after HALT
    do_reset();
    cyc(0, 0, '0, '0);
    cyc(1, 2'd1, 56'h300, '0);
    cyc(1, 2'd2, 56'h301, '0);
    cyc(1, 2'd3, 56'h0, '0);
    chk("halt_ready_low", cif.cmd_ready, 0);
    cyc(1, 2'd1, 56'h302, '0);
    chk("drain_busy", eng_busy, 4'h3);
    cyc(0, 0, '0, 4'h1);
    cyc(0, 0, '0, 4'h2);
    chk("drain_not_halted", halted, 0);
    chk("drain_idle", eng_busy, 4'h0);
    cyc(0, 0, '0, '0);
    chk("halted_set", halted, 1);
    chk("halted_cnt", cmpl_cnt, 2);
    cyc(1, 2'd1, 56'h303, '0);
    chk("halted_no_start", eng_start, 4'h0);
    chk("halted_ready", cif.cmd_ready, 0);
    chk("halted_sticky", halted, 1);

    // spurious done alongside a valid one
    do_reset();
    cyc(0, 0, '0, '0);
    cyc(1, 2'd1, 56'h400, '0);
    cyc(1, 2'd1, 56'h401, '0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, 4'hA);
    chk("spur_err", err_spurious, 1);
    chk("spur_cnt", cmpl_cnt, 1);
    chk("spur_busy", eng_busy, 4'h1);

    // asynchronous reset with engines busy and commands queued
    do_reset();
    cyc(0, 0, '0, '0);
    for (int i = 0; i < 7; i++) cyc(1, 2'd2, AW'(56'h500 + i), '0);
    chk("pre_rst_busy", eng_busy, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", eng_busy, 4'h0);
    chk("arst_addr", eng_addr, '0);
    chk("arst_mode", eng_mode, 4'h0);
    chk("arst_ready", cif.cmd_ready, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0);
    chk("post_rst_busy", eng_busy, 4'h0);
    cyc(0, 0, '0, 4'h1);
    chk("post_rst_spur", err_spurious, 1);
    chk("post_rst_cnt", cmpl_cnt, 0);

    // random traffic
    do_reset();
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0 || hcnt > 5) begin
        do_reset();
        hcnt = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 8) op = 2'd0;
      else if (r < 50) op = 2'd1;
      else if (r < 99) op = 2'd2;
      else op = 2'd3;
      a = {$urandom, $urandom};
      for (int i = 0; i < NE; i++) begin
        if (m_busy[i]) d[i] = ($urandom_range(0, 3) == 0);
        else d[i] = ($urandom_range(0, 63) == 0);
      end
      cyc(v, op, a, d);
      if (m_halted) hcnt++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
